mult_fu: RTL
============

// Module: mult_fu
// PURPOSE
//  Pipelined integer multiply functional unit; producer side of the CDB result handshake.
//  - Accepts one RV32M multiply per cycle from the issue stage.
//  - Computes the product over MULT_STAGES register stages.
//  - Presents each finished result as mult_prepared/mult_packet.
//  - Holds a result until the CDB signals mult_avail, stalling upstream stages as needed.
// PARAMETERS
//  MULT_STAGES  4  pipeline depth; must divide 64; each stage adds 64/MULT_STAGES multiplier bits
// PORTS
//  clock          in   1                  clock
//  reset          in   1                  synchronous, active-high reset
//  squash         in   1                  mispredict flush; kills every in-flight op
//  issue_valid    in   1                  issue_packet holds a valid multiply
//  issue_packet   in   MULT_ISSUE_PACKET  {rs1, rs2 (DATA), func (MULT_FUNC), robn (ROBN), dest_prn (PRN)}
//  issue_ready    out  1                  FU accepts issue_packet at this edge
//  mult_avail     in   1                  CDB takes/ignores output at this edge (selected | ~prepared)
//  mult_prepared  out  1                  mult_packet holds a finished result
//  mult_packet    out  MULT_PACKET        {robn, dest_prn, result (DATA)}
// BEHAVIOUR
//  Reset
//   - reset is synchronous, active-high; clock is clock.
//   - reset clears every stage valid bit, so mult_prepared=0 and issue_ready=1.
//   - mult_packet is all-zero after reset.
//  Pipeline
//   - Registers are S1..S_MULT_STAGES; each holds valid, func, robn, dest_prn,
//     64b mcand, 64b mplier, 64b acc.
//   - Operand extension: MULH sign-extends both operands to 64b.
//     MULHSU sign-extends rs1 and zero-extends rs2. MUL and MULHU zero-extend both.
//   - Step k (k=0..MULT_STAGES-1), with C = 64/MULT_STAGES:
//     acc += mcand * mplier[k*C +: C] << (k*C), truncated to 64b.
//   - Step 0 is combinational between the issue input and S1. Step k is between S_k and S_k+1.
//   - The final stage presents the result combinationally:
//     MUL selects acc[31:0]; MULH, MULHSU and MULHU select acc[63:32].
//  Latency and throughput
//   - An op issued in cycle c shows mult_prepared=1 in cycle c+MULT_STAGES when nothing stalls.
//   - Peak throughput is 1 op/cycle.
//  Handshake (per stage, ready/valid)
//   - Output transfers at the edge where mult_prepared && mult_avail.
//   - adv_last = mult_avail (also true when the last stage is empty).
//   - adv_k = ~S_k+1.valid | adv_k+1.
//   - issue_ready = adv_0 (S1 empty or advancing). This is combinational from mult_avail.
//   - An issue with issue_valid && ~issue_ready is not consumed; the issuer re-presents it.
//   - A stalled stage holds every field unchanged; mult_packet is stable while mult_prepared=1 && ~mult_avail.
//   - Bubbles collapse: an empty stage refills even when later stages stall.
//  Squash
//   - Clears all valid bits at the next edge.
//   - Takes priority over a simultaneous issue; that issue is dropped.
//   - An output transfer at the squash edge still counts as complete; the CDB owns that flush.
//   - Squash during a stall drops the held result.
//  Edge cases
//   - Reset mid-operation is identical to squash.
//   - Operands 0, 0x80000000 and 0xFFFFFFFF need no special case.
// STRUCTURE
//  - Shared package sys_defs: MULT_FUNC enum {MUL, MULH, MULHSU, MULHU}, MULT_ISSUE_PACKET,
//    MULT_PACKET, DATA, ROBN, PRN.
//  - Sub-module mult_stage: one step of combinational partial-product accumulation plus its
//    register, parameterised by chunk index.
//  - mult_fu instantiates MULT_STAGES copies in a generate loop.
//  - mult_fu owns the ready chain, squash and result select.
// TESTING
//  - MUL rs1=3, rs2=0xFFFFFFFE, issued cycle 0, mult_avail=1
//    -> prepared in cycle 4, result 0xFFFFFFFA, robn/dest_prn echoed.
//  - High-half checks:
//    MULH 0x80000000*0x80000000 -> 0x40000000;
//    MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  - Back-to-back issue of 8 ops, mult_avail=1
//    -> issue_ready stays 1; results appear on 8 consecutive cycles in issue order.
//  - Stall: hold mult_avail=0 for 6 cycles while issuing 6 ops
//    -> output stable; issue_ready drops after 4 accepts; release yields all results in order with none lost.
//  - Squash with 3 in flight plus a concurrent issue
//    -> prepared=0 the next cycle; no stale results appear later.
//  - Reset while stalled with a full pipe -> prepared=0, issue_ready=1 the next cycle.

Source files
------------

// File: rtl/mult_fu_pkg.sv
// Shared types for the multiply functional unit: operation encodings, the issue and CDB
// packets, the per-stage pipeline register and the helpers that prepare and select data.
package sys_defs;

  localparam int XLEN       = 32;
  localparam int PROD_W     = 2 * XLEN;
  localparam int ROB_SZ     = 32;
  localparam int PHYS_REGS  = 64;
  localparam int ROBN_W     = $clog2(ROB_SZ);
  localparam int PRN_W      = $clog2(PHYS_REGS);

  typedef logic [XLEN-1:0]   DATA;
  typedef logic [ROBN_W-1:0] ROBN;
  typedef logic [PRN_W-1:0]  PRN;

  typedef enum logic [1:0] {
    MUL    = 2'h0,
    MULH   = 2'h1,
    MULHSU = 2'h2,
    MULHU  = 2'h3
  } MULT_FUNC;

  typedef struct packed {
    DATA      rs1;
    DATA      rs2;
    MULT_FUNC func;
    ROBN      robn;
    PRN       dest_prn;
  } MULT_ISSUE_PACKET;

  typedef struct packed {
    ROBN robn;
    PRN  dest_prn;
    DATA result;
  } MULT_PACKET;

  // One pipeline register: tag fields ride alongside the partially accumulated product.
  typedef struct packed {
    logic              valid;
    MULT_FUNC          func;
    ROBN               robn;
    PRN                dest_prn;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] mplier;
    logic [PROD_W-1:0] acc;
  } MULT_STAGE_REG;

  function automatic logic [PROD_W-1:0] extend_operand(input DATA value, input logic is_signed);
    return is_signed ? {{XLEN{value[XLEN-1]}}, value} : {{XLEN{1'b0}}, value};
  endfunction

  function automatic logic rs1_is_signed(input MULT_FUNC func);
    return (func == MULH) || (func == MULHSU);
  endfunction

  function automatic logic rs2_is_signed(input MULT_FUNC func);
    return func == MULH;
  endfunction

  function automatic DATA select_result(input MULT_FUNC func, input logic [PROD_W-1:0] acc);
    return (func == MUL) ? acc[XLEN-1:0] : acc[PROD_W-1:XLEN];
  endfunction

endpackage

// File: rtl/mult_fu_stage.sv
// One multiply step: adds the partial product for multiplier chunk CHUNK_IDX into the
// accumulator, then registers the result when the downstream chain lets this stage advance.
module mult_stage
  import sys_defs::*;
#(
  parameter int MULT_STAGES = 4,
  parameter int CHUNK_IDX   = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          advance,
  input  MULT_STAGE_REG stage_in,
  output MULT_STAGE_REG stage_out
);

  localparam int CHUNK_W = PROD_W / MULT_STAGES;
  localparam int SHIFT   = CHUNK_IDX * CHUNK_W;

  logic [PROD_W-1:0] chunk;
  logic [PROD_W-1:0] partial;
  MULT_STAGE_REG     stage_next;

  // NOTE: every variable written here gets a value before any conditional use, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stage_next     = stage_in;
    chunk          = PROD_W'(stage_in.mplier[SHIFT +: CHUNK_W]);
    partial        = (stage_in.mcand * chunk) << SHIFT;
    stage_next.acc = stage_in.acc + partial;
  end

  // NOTE: the datapath fields are cleared by reset too, not just valid, so the result
  // bus reads all-zero after reset instead of whatever the flops powered up with.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_out <= '0;
    end else if (flush) begin
      stage_out.valid <= 1'b0;
    end else if (advance) begin
      stage_out <= stage_next;
    end
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: extends operands at issue, accumulates one multiplier
// chunk per stage, and holds the finished product until the CDB takes it.
module mult_fu
  import sys_defs::*;
#(
  parameter int MULT_STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             issue_valid,
  input  MULT_ISSUE_PACKET issue_packet,
  output logic             issue_ready,
  input  logic             mult_avail,
  output logic             mult_prepared,
  output MULT_PACKET       mult_packet
);

  MULT_STAGE_REG          issue_stage;
  MULT_STAGE_REG          stage_in [MULT_STAGES];
  MULT_STAGE_REG          stage_q  [MULT_STAGES];
  logic [MULT_STAGES-1:0] adv;
  logic                   adv_carry;

  always_comb begin
    issue_stage          = '0;
    issue_stage.valid    = issue_valid;
    issue_stage.func     = issue_packet.func;
    issue_stage.robn     = issue_packet.robn;
    issue_stage.dest_prn = issue_packet.dest_prn;
    issue_stage.mcand    = extend_operand(issue_packet.rs1, rs1_is_signed(issue_packet.func));
    issue_stage.mplier   = extend_operand(issue_packet.rs2, rs2_is_signed(issue_packet.func));
  end

  // Ready chain, walked from the output back to issue: a stage may load when it is empty
  // or when its own contents move on. An empty last stage always counts as draining.
  // NOTE: adv_carry is a combinational temporary, so it uses blocking assignments and each
  // loop iteration sees the value left by the previous one.
  always_comb begin
    adv       = '0;
    adv_carry = mult_avail;
    for (int k = MULT_STAGES - 1; k >= 0; k--) begin
      adv_carry = adv_carry | ~stage_q[k].valid;
      adv[k]    = adv_carry;
    end
  end

  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = issue_stage;
    end else begin : g_body
      assign stage_in[k] = stage_q[k-1];
    end

    mult_stage #(
      .MULT_STAGES (MULT_STAGES),
      .CHUNK_IDX   (k)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (squash),
      .advance   (adv[k]),
      .stage_in  (stage_in[k]),
      .stage_out (stage_q[k])
    );
  end

  assign issue_ready          = adv[0];
  assign mult_prepared        = stage_q[MULT_STAGES-1].valid;
  assign mult_packet.robn     = stage_q[MULT_STAGES-1].robn;
  assign mult_packet.dest_prn = stage_q[MULT_STAGES-1].dest_prn;
  assign mult_packet.result   = select_result(stage_q[MULT_STAGES-1].func,
                                              stage_q[MULT_STAGES-1].acc);

endmodule
